// File: rtl/saxl_lfsr_gen_if.sv
// saxl_lfsr_gen_if: bundles the AXI-Lite slave channels and the AXI-Stream
// master channel of the LFSR generator.
//   s_axi_aw*/w*/b*  write address, data, response
//   s_axi_ar*/r*     read address, data
//   m_axis_*         generated state stream
// Modport slave is the generator's view, master is the CPU/sink view.
interface saxl_lfsr_gen_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic [AW-1:0] s_axi_awaddr;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic [AW-1:0] s_axi_araddr;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, output s_axi_awready,
        input  s_axi_wdata, s_axi_wvalid, output s_axi_wready,
        output s_axi_bresp, s_axi_bvalid, input s_axi_bready,
        input  s_axi_araddr, s_axi_arvalid, output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid, input s_axi_rready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, input m_axis_tready
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, input s_axi_awready,
        output s_axi_wdata, s_axi_wvalid, input s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid, output s_axi_bready,
        output s_axi_araddr, s_axi_arvalid, input s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid, output s_axi_rready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, output m_axis_tready
    );
endinterface

// File: rtl/saxl_lfsr_gen.sv
// saxl_lfsr_gen: LFSR_WIDTH-bit Fibonacci/Galois generator configured over
// AXI-Lite, streaming its state as counted (or continuous) AXI-Stream bursts.
//   aclk    clock, rising edge
//   areset  synchronous reset, active high
//   bus     saxl_lfsr_gen_if.slave: AXI-Lite slave + AXI-Stream master
module saxl_lfsr_gen #(
    parameter int C_AXIL_ADDR_WIDTH = 5,
    parameter int C_AXIL_DATA_WIDTH = 32,
    parameter int LFSR_WIDTH        = 16,
    parameter int LEN_WIDTH         = 16
) (
    input  logic           aclk,
    input  logic           areset,
    saxl_lfsr_gen_if.slave bus
);
    localparam int AW = C_AXIL_ADDR_WIDTH;
    localparam int DW = C_AXIL_DATA_WIDTH;
    localparam int LW = LFSR_WIDTH;
    localparam logic [AW-1:0] A_CTRL   = AW'(8'h00);
    localparam logic [AW-1:0] A_SEED   = AW'(8'h04);
    localparam logic [AW-1:0] A_TAPS   = AW'(8'h08);
    localparam logic [AW-1:0] A_LEN    = AW'(8'h0C);
    localparam logic [AW-1:0] A_STATUS = AW'(8'h10);
    localparam logic [AW-1:0] A_STATE  = AW'(8'h14);
    localparam logic [AW-1:0] A_COUNT  = AW'(8'h18);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;
    state_t r_fsm, w_fsm_nxt;

    // Configuration registers (take effect at the next start)
    logic [LW-1:0]        r_seed, r_taps;
    logic [LEN_WIDTH-1:0] r_len;
    logic                 r_mode;
    // Working copies latched at start
    logic [LW-1:0]        r_state, r_wtaps;
    logic [LEN_WIDTH-1:0] r_wlen;
    logic                 r_wmode, r_seed_fixed;
    logic [31:0]          r_count;
    // AXI-Lite write/read channel state
    logic                 r_awready, r_wready, r_aw_held, r_w_held, r_bvalid;
    logic [1:0]           r_bresp, r_rresp;
    logic [AW-1:0]        r_awaddr;
    logic [DW-1:0]        r_wdata, r_rdata, w_rd_data;
    logic                 r_arready, r_rvalid;
    logic [1:0]           w_rd_resp;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_wr_fire, w_ctrl_wr;
    logic w_start, w_stop, w_hs, w_tvalid, w_tlast, w_last_calc, w_fb, w_wr_ok;
    logic [LW-1:0] w_lfsr_nxt;
    logic w_unused_wdata;

    assign w_aw_hs   = bus.s_axi_awvalid & r_awready;
    assign w_w_hs    = bus.s_axi_wvalid & r_wready;
    assign w_b_hs    = r_bvalid & bus.s_axi_bready;
    assign w_ar_hs   = bus.s_axi_arvalid & r_arready;
    assign w_r_hs    = r_rvalid & bus.s_axi_rready;
    // Commit exactly once: the held beats stay held until B completes.
    assign w_wr_fire = r_aw_held & r_w_held & ~r_bvalid;
    assign w_wr_ok   = (r_awaddr[1:0] == 2'b00) && (r_awaddr <= A_COUNT);
    assign w_ctrl_wr = w_wr_fire & (r_awaddr == A_CTRL);
    // Stop takes priority over start in the same write.
    assign w_start   = w_ctrl_wr & r_wdata[0] & ~r_wdata[1] & (r_fsm == S_IDLE);
    assign w_stop    = w_ctrl_wr & r_wdata[1];
    assign w_hs      = w_tvalid & bus.m_axis_tready;
    assign w_unused_wdata = ^r_wdata;

    assign w_last_calc = (r_wlen != '0) && (r_count == 32'(r_wlen) - 32'd1);
    assign w_fb        = ^(r_state & r_wtaps);
    assign w_lfsr_nxt  = r_wmode ? ((r_state >> 1) ^ (r_state[0] ? r_wtaps : '0))
                                 : {r_state[LW-2:0], w_fb};

    assign bus.s_axi_awready = r_awready;
    assign bus.s_axi_wready  = r_wready;
    assign bus.s_axi_bvalid  = r_bvalid;
    assign bus.s_axi_bresp   = r_bresp;
    assign bus.s_axi_arready = r_arready;
    assign bus.s_axi_rvalid  = r_rvalid;
    assign bus.s_axi_rdata   = r_rdata;
    assign bus.s_axi_rresp   = r_rresp;
    assign bus.m_axis_tvalid = w_tvalid;
    assign bus.m_axis_tlast  = w_tlast;
    assign bus.m_axis_tdata  = w_tvalid ? DW'(r_state) : '0;

    // Write channel and configuration registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_awready <= 1'b0; r_wready <= 1'b0;
            r_aw_held <= 1'b0; r_w_held <= 1'b0;
            r_bvalid  <= 1'b0; r_bresp  <= OKAY;
            r_awaddr  <= '0;   r_wdata  <= '0;
            r_seed    <= LW'(1); r_taps <= '0; r_len <= '0; r_mode <= 1'b0;
        end else begin
            if (w_aw_hs) begin r_aw_held <= 1'b1; r_awaddr <= bus.s_axi_awaddr; end
            if (w_w_hs)  begin r_w_held  <= 1'b1; r_wdata  <= bus.s_axi_wdata;  end
            // Ready drops once a beat is held and returns after the B handshake.
            r_awready <= w_b_hs | ~(r_aw_held | w_aw_hs);
            r_wready  <= w_b_hs | ~(r_w_held | w_w_hs);
            if (w_b_hs) begin
                r_aw_held <= 1'b0; r_w_held <= 1'b0; r_bvalid <= 1'b0;
            end
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? OKAY : SLVERR;
                case (r_awaddr)
                    A_CTRL:  r_mode <= r_wdata[2];
                    A_SEED:  r_seed <= r_wdata[LW-1:0];
                    A_TAPS:  r_taps <= r_wdata[LW-1:0];
                    A_LEN:   r_len  <= r_wdata[LEN_WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Read mux
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = OKAY;
        case (bus.s_axi_araddr)
            A_CTRL:   w_rd_data = DW'({r_mode, 2'b00});
            A_SEED:   w_rd_data = DW'(r_seed);
            A_TAPS:   w_rd_data = DW'(r_taps);
            A_LEN:    w_rd_data = DW'(r_len);
            A_STATUS: w_rd_data = DW'({r_seed_fixed, r_fsm != S_IDLE});
            A_STATE:  w_rd_data = DW'(r_state);
            A_COUNT:  w_rd_data = DW'(r_count);
            default:  w_rd_resp = SLVERR;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_arready <= 1'b0; r_rvalid <= 1'b0;
            r_rdata   <= '0;   r_rresp  <= OKAY;
        end else begin
            if (w_ar_hs) begin
                r_rvalid <= 1'b1; r_rdata <= w_rd_data; r_rresp <= w_rd_resp;
            end else if (w_r_hs) begin
                r_rvalid <= 1'b0;
            end
            r_arready <= ~(w_ar_hs | (r_rvalid & ~w_r_hs));
        end
    end

    // Stream FSM: state register and datapath
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_fsm   <= S_IDLE;
            r_state <= '0; r_wtaps <= '0; r_wlen <= '0; r_wmode <= 1'b0;
            r_count <= '0; r_seed_fixed <= 1'b0;
        end else begin
            r_fsm <= w_fsm_nxt;
            if (w_start) begin
                // All-zero seed would lock the LFSR; substitute 1 and flag it.
                r_state      <= (r_seed == '0) ? LW'(1) : r_seed;
                r_seed_fixed <= (r_seed == '0);
                r_wtaps      <= r_taps;
                r_wlen       <= r_len;
                r_wmode      <= r_wdata[2];
                r_count      <= '0;
            end else if (w_hs) begin
                r_state <= w_lfsr_nxt;
                r_count <= r_count + 32'd1;
            end
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        w_tvalid  = 1'b0;
        w_tlast   = 1'b0;
        case (r_fsm)
            S_IDLE: if (w_start) w_fsm_nxt = S_RUN;
            S_RUN: begin
                w_tvalid = 1'b1;
                w_tlast  = w_last_calc;
                if (w_hs && w_last_calc) w_fsm_nxt = S_IDLE;
                else if (w_stop)         w_fsm_nxt = w_hs ? S_IDLE : S_STOP;
            end
            S_STOP: begin
                w_tvalid = 1'b1;
                w_tlast  = 1'b1;
                if (w_hs) w_fsm_nxt = S_IDLE;
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_saxl_lfsr_gen.sv
module tb_saxl_lfsr_gen;
    localparam int AW = 6, DW = 32, LW = 8, LENW = 16;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    saxl_lfsr_gen_if #(.AW(AW), .DW(DW)) bus ();

    saxl_lfsr_gen #(
        .C_AXIL_ADDR_WIDTH(AW), .C_AXIL_DATA_WIDTH(DW),
        .LFSR_WIDTH(LW), .LEN_WIDTH(LENW)
    ) dut (
        .aclk(aclk), .areset(areset), .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: next LFSR value from the textual rules, using integer arithmetic.
    function automatic logic [LW-1:0] model_next(input bit galois, input int unsigned s,
                                                 input int unsigned t);
        int unsigned ones;
        ones = 0;
        if (galois) return LW'((s / 2) ^ ((s % 2 == 1) ? t : 0));
        for (int i = 0; i < LW; i++)
            if ((((s >> i) & 1) == 1) && (((t >> i) & 1) == 1)) ones++;
        return LW'((s * 2 + ones % 2) % (1 << LW));
    endfunction

    task automatic axil_write(input logic [AW-1:0] a, input logic [31:0] d,
                              input int w_lead, output logic [1:0] resp);
        int cyc;
        bit aw_on, aw_done, w_done, hs_aw, hs_w;
        @(negedge aclk);
        bus.s_axi_wdata = d; bus.s_axi_wvalid = 1'b1;
        aw_on = 0; aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 100) begin
            if (!aw_on && !aw_done && cyc >= w_lead) begin
                bus.s_axi_awaddr = a; bus.s_axi_awvalid = 1'b1; aw_on = 1;
            end
            hs_aw = bus.s_axi_awvalid && bus.s_axi_awready;
            hs_w  = bus.s_axi_wvalid && bus.s_axi_wready;
            @(negedge aclk); cyc++;
            if (hs_aw) begin bus.s_axi_awvalid = 1'b0; aw_done = 1; aw_on = 0; end
            if (hs_w)  begin bus.s_axi_wvalid = 1'b0; w_done = 1; end
        end
        if (!(aw_done && w_done)) check("wr_addr_data_timeout", 0, 1);
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b1; cyc = 0;
        while (!bus.s_axi_bvalid && cyc < 100) begin @(negedge aclk); cyc++; end
        if (!bus.s_axi_bvalid) check("wr_resp_timeout", 0, 1);
        resp = bus.s_axi_bresp;
        @(negedge aclk);
        bus.s_axi_bready = 1'b0;
    endtask

    task automatic axil_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        int cyc;
        @(negedge aclk);
        bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1; cyc = 0;
        while (!bus.s_axi_arready && cyc < 100) begin @(negedge aclk); cyc++; end
        if (!bus.s_axi_arready) check("rd_addr_timeout", 0, 1);
        bus.s_axi_rready = 1'b1;
        @(negedge aclk);
        bus.s_axi_arvalid = 1'b0; cyc = 0;
        while (!bus.s_axi_rvalid && cyc < 100) begin @(negedge aclk); cyc++; end
        if (!bus.s_axi_rvalid) check("rd_data_timeout", 0, 1);
        d = bus.s_axi_rdata; resp = bus.s_axi_rresp;
        @(negedge aclk);
        bus.s_axi_rready = 1'b0;
    endtask

    task automatic wr_ok(input logic [AW-1:0] a, input logic [31:0] d, input string tag);
        logic [1:0] r;
        axil_write(a, d, 0, r);
        check(tag, 64'(r), 64'd0);
    endtask

    task automatic rd_check(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d; logic [1:0] r;
        axil_read(a, d, r);
        check(tag, {30'd0, r, d}, {32'd0, exp});
    endtask

    // Consume n_beats handshakes, comparing each beat with the model and
    // checking that a stalled beat does not change. Leaves tready low.
    task automatic stream_check(input bit galois, input logic [LW-1:0] seed, input logic [LW-1:0] taps,
                                input int len, input int n_beats, input int rdy_pct,
                                input string tag, output logic [LW-1:0] exp_out);
        int got, cyc;
        bit prev_stall, rdy;
        logic [DW-1:0] prev_data;
        logic [LW-1:0] exp;
        exp = (seed == '0) ? LW'(1) : seed;
        got = 0; cyc = 0; prev_stall = 0; prev_data = '0;
        while (got < n_beats && cyc < 2000) begin
            @(negedge aclk); cyc++;
            if (prev_stall) begin
                check({tag, "_stall_valid"}, 64'(bus.m_axis_tvalid), 64'd1);
                check({tag, "_stall_data"}, 64'(bus.m_axis_tdata), 64'(prev_data));
            end
            rdy = ($urandom_range(99) < rdy_pct);
            bus.m_axis_tready = rdy;
            if (bus.m_axis_tvalid && rdy) begin
                check({tag, "_data"}, 64'(bus.m_axis_tdata), 64'(exp));
                check({tag, "_last"}, 64'(bus.m_axis_tlast), 64'(len != 0 && got == len - 1));
                exp = model_next(galois, exp, taps);
                got++;
            end
            prev_stall = bus.m_axis_tvalid && !rdy;
            prev_data  = bus.m_axis_tdata;
        end
        if (got < n_beats) check({tag, "_beat_timeout"}, 64'(got), 64'(n_beats));
        @(negedge aclk);
        bus.m_axis_tready = 1'b0;
        exp_out = exp;
    endtask

    initial begin
        logic [LW-1:0] seed, taps, nxt;
        logic [31:0] d;
        logic [1:0] r;
        int len;
        bit gal;

        bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0;  bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0;
        bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
        bus.m_axis_tready = 1'b0;

        repeat (3) @(negedge aclk);
        check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(bus.m_axis_tlast), 64'd0);
        check("rst_tdata", 64'(bus.m_axis_tdata), 64'd0);
        check("rst_readies", {61'd0, bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 64'd0);
        check("rst_valids", {62'd0, bus.s_axi_bvalid, bus.s_axi_rvalid}, 64'd0);
        check("rst_rdata", 64'(bus.s_axi_rdata), 64'd0);
        areset = 1'b0;
        repeat (2) @(negedge aclk);
        rd_check(6'h04, 32'h1, "rst_seed");
        rd_check(6'h08, 32'h0, "rst_taps");
        rd_check(6'h0C, 32'h0, "rst_len");
        rd_check(6'h00, 32'h0, "rst_ctrl");
        rd_check(6'h10, 32'h0, "rst_status");

        // Fibonacci 4-beat burst
        wr_ok(6'h04, 32'h01, "fib_wr_seed");
        wr_ok(6'h08, 32'hB8, "fib_wr_taps");
        wr_ok(6'h0C, 32'd4, "fib_wr_len");
        wr_ok(6'h00, 32'h1, "fib_wr_start");
        stream_check(1'b0, 8'h01, 8'hB8, 4, 4, 100, "fib", nxt);
        check("fib_idle_after", 64'(bus.m_axis_tvalid), 64'd0);
        rd_check(6'h10, 32'h0, "fib_status");
        rd_check(6'h18, 32'd4, "fib_count");

        // Galois 3-beat burst
        wr_ok(6'h0C, 32'd3, "gal_wr_len");
        wr_ok(6'h00, 32'h5, "gal_wr_start");
        stream_check(1'b1, 8'h01, 8'hB8, 3, 3, 100, "gal", nxt);
        rd_check(6'h18, 32'd3, "gal_count");
        rd_check(6'h00, 32'h4, "gal_ctrl_rd");

        // Randomized bursts with random backpressure
        for (int k = 0; k < 4; k++) begin
            seed = LW'($urandom_range(1, 255));
            taps = LW'($urandom_range(1, 255));
            len  = $urandom_range(1, 9);
            gal  = $urandom_range(1);
            wr_ok(6'h04, 32'(seed), "rnd_wr_seed");
            wr_ok(6'h08, 32'(taps), "rnd_wr_taps");
            wr_ok(6'h0C, 32'(len), "rnd_wr_len");
            wr_ok(6'h00, {29'd0, gal, 2'b01}, "rnd_wr_start");
            stream_check(gal, seed, taps, len, len, 60, "rnd", nxt);
            rd_check(6'h18, 32'(len), "rnd_count");
            rd_check(6'h10, 32'h0, "rnd_status");
        end

        // Continuous mode, toggled ready, stop during a stall
        seed = LW'($urandom_range(1, 255));
        taps = LW'($urandom_range(1, 255));
        wr_ok(6'h04, 32'(seed), "cont_wr_seed");
        wr_ok(6'h08, 32'(taps), "cont_wr_taps");
        wr_ok(6'h0C, 32'd0, "cont_wr_len");
        wr_ok(6'h00, 32'h1, "cont_wr_start");
        stream_check(1'b0, seed, taps, 0, 20, 50, "cont", nxt);
        check("cont_pre_stop_data", 64'(bus.m_axis_tdata), 64'(nxt));
        check("cont_pre_stop_last", 64'(bus.m_axis_tlast), 64'd0);
        wr_ok(6'h00, 32'h2, "cont_wr_stop");
        check("stop_valid", 64'(bus.m_axis_tvalid), 64'd1);
        check("stop_data", 64'(bus.m_axis_tdata), 64'(nxt));
        check("stop_last", 64'(bus.m_axis_tlast), 64'd1);
        rd_check(6'h10, 32'h1, "stop_status_busy");
        @(negedge aclk); bus.m_axis_tready = 1'b1;
        @(negedge aclk); bus.m_axis_tready = 1'b0;
        check("stop_done_idle", 64'(bus.m_axis_tvalid), 64'd0);

        // Zero seed is replaced by 1
        wr_ok(6'h04, 32'h0, "z_wr_seed");
        wr_ok(6'h0C, 32'd2, "z_wr_len");
        wr_ok(6'h00, 32'h1, "z_wr_start");
        rd_check(6'h10, 32'h3, "z_status_busy");
        stream_check(1'b0, 8'h00, taps, 2, 2, 100, "z", nxt);
        rd_check(6'h10, 32'h2, "z_status_sticky");
        axil_read(6'h1C, d, r);
        check("rd_unmapped", {30'd0, r, d}, {30'd0, 2'b10, 32'd0});

        // W leads AW by 3 cycles
        taps = LW'($urandom_range(1, 255));
        axil_write(6'h08, {24'hA5A5A5, taps}, 3, r);
        check("wlead_bresp", 64'(r), 64'd0);
        check("wlead_single_b", 64'(bus.s_axi_bvalid), 64'd0);
        @(negedge aclk);
        check("wlead_single_b2", 64'(bus.s_axi_bvalid), 64'd0);
        rd_check(6'h08, 32'(taps), "wlead_taps_rd");

        // Unmapped write; start+stop together in IDLE
        axil_write(6'h20, 32'hFFFF_FFFF, 0, r);
        check("wr_unmapped", 64'(r), 64'd2);
        axil_read(6'h20, d, r);
        check("rd_unmapped_20", {30'd0, r, d}, {30'd0, 2'b10, 32'd0});
        rd_check(6'h08, 32'(taps), "unmapped_taps_kept");
        wr_ok(6'h00, 32'h3, "ss_wr");
        repeat (2) @(negedge aclk);
        check("ss_no_burst", 64'(bus.m_axis_tvalid), 64'd0);
        rd_check(6'h10, 32'h2, "ss_status");

        // Reset in the middle of a continuous burst
        wr_ok(6'h04, 32'h5, "rb_wr_seed");
        wr_ok(6'h0C, 32'd0, "rb_wr_len");
        wr_ok(6'h00, 32'h1, "rb_wr_start");
        bus.m_axis_tready = 1'b1;
        repeat (4) @(negedge aclk);
        check("rb_running", 64'(bus.m_axis_tvalid), 64'd1);
        areset = 1'b1;
        @(negedge aclk);
        check("rb_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("rb_tlast", 64'(bus.m_axis_tlast), 64'd0);
        bus.m_axis_tready = 1'b0;
        areset = 1'b0;
        @(negedge aclk);
        rd_check(6'h04, 32'h1, "rb_seed");
        rd_check(6'h10, 32'h0, "rb_status");
        rd_check(6'h0C, 32'h0, "rb_len");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
